mux_row_accumulator: RTL and testbench



---
 rtl/mux_row_accumulator.sv | 169 ++++++++++++++++
 tb/tb_mux_row_accumulator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_row_accumulator.sv
// mux_row_accumulator
// Sums ACC_STEPS beats of four signed lane values into four row results.
// Results are saturated to WIDTH bits with a per-lane clip flag and are
// offered through a valid/ready handshake. A synchronous clear drops any
// partial or held result so the block can realign to the select sequence.
//
// Note: rst_n is active-HIGH and asynchronous despite its name.
//
// state | meaning
// ------+------------------------------------------------------------
// ACCUM | accepting beats, summing lanes, in_ready high once out of reset
// HOLD  | result presented on out0..out3/ovf, waiting for out_ready

module mux_row_accumulator #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 8,
    parameter int ACC_STEPS = 4,
    parameter int CNT_W     = $clog2(ACC_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       ovf,
    output logic [CNT_W-1:0] beat_cnt
);

    // Accumulator width: CNT_W extra bits cover ACC_STEPS worst-case beats.
    localparam int AW = WIDTH + CNT_W;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(CNT_W + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(CNT_W + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_STEPS - 1);

    // Reject nonsensical parameterisations at elaboration.
    if (ACC_STEPS < 1 || FRAC >= WIDTH) begin : g_param_check
        $error("mux_row_accumulator: need ACC_STEPS >= 1 and FRAC < WIDTH");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q [4];
    logic signed [AW-1:0]    acc_d [4];
    logic        [WIDTH-1:0] res_q [4];
    logic        [WIDTH-1:0] res_d [4];
    logic        [3:0]       ovf_q, ovf_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    started_q, started_d;

    logic        [WIDTH-1:0] lane_in  [4];
    logic signed [AW-1:0]    lane_sum [4];
    logic        [WIDTH-1:0] lane_sat [4];
    logic        [3:0]       lane_clip;
    logic                    accept;

    assign lane_in[0] = in0;
    assign lane_in[1] = in1;
    assign lane_in[2] = in2;
    assign lane_in[3] = in3;

    // Handshake outputs decoded from state; in_ready waits one edge after reset.
    assign in_ready  = started_q & (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;

    assign out0     = res_q[0];
    assign out1     = res_q[1];
    assign out2     = res_q[2];
    assign out3     = res_q[3];
    assign ovf      = ovf_q;
    assign beat_cnt = cnt_q;

    // Per-lane running sum with the current beat, and its saturated form.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_sum[k]  = acc_q[k] + {{CNT_W{lane_in[k][WIDTH-1]}}, lane_in[k]};
            lane_clip[k] = 1'b0;
            lane_sat[k]  = lane_sum[k][WIDTH-1:0];
            if (lane_sum[k] > SAT_MAX) begin
                lane_sat[k]  = SAT_MAX[WIDTH-1:0];
                lane_clip[k] = 1'b1;
            end else if (lane_sum[k] < SAT_MIN) begin
                lane_sat[k]  = SAT_MIN[WIDTH-1:0];
                lane_clip[k] = 1'b1;
            end
        end
    end

    // Next-state: clear beats everything, then HOLD handshake or ACCUM beat.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        started_d = 1'b1;

        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
            ovf_d   = '0;
            for (int k = 0; k < 4; k++) acc_d[k] = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = lane_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = HOLD;
                            res_d   = lane_sat;
                            ovf_d   = lane_clip;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        cnt_d   = '0;
                        ovf_d   = '0;
                        for (int k = 0; k < 4; k++) acc_d[k] = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State, accumulators and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ACCUM;
            ovf_q     <= '0;
            cnt_q     <= '0;
            started_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= acc_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

endmodule

// File: tb/tb_mux_row_accumulator.sv
// Testbench for mux_row_accumulator: directed scenarios plus random traffic,
// checked every cycle against an integer-arithmetic model of the result rules.

module tb_mux_row_accumulator;

    localparam int W     = 16;
    localparam int STEPS = 4;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int MAXV  = (1 << (W - 1)) - 1;
    localparam int MINV  = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out0, out1, out2, out3;
    logic [3:0]    ovf;
    logic [CW-1:0] beat_cnt;

    int errors = 0;
    int checks = 0;

    mux_row_accumulator #(.WIDTH(W), .FRAC(8), .ACC_STEPS(STEPS)) dut (
        .clk(clk), .rst_n(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .ovf(ovf), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        m_sum [4];
    int        m_beats;
    bit        m_hold;
    bit        m_alive;
    int        m_out [4];
    bit [3:0]  m_ovf;

    function automatic int sat(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        int lane [4];
        if (rst) begin
            for (int k = 0; k < 4; k++) begin m_sum[k] = 0; m_out[k] = 0; end
            m_beats = 0; m_hold = 0; m_alive = 0; m_ovf = '0;
        end else begin
            lane[0] = $signed(in0); lane[1] = $signed(in1);
            lane[2] = $signed(in2); lane[3] = $signed(in3);
            if (clear) begin
                for (int k = 0; k < 4; k++) m_sum[k] = 0;
                m_beats = 0; m_hold = 0; m_ovf = '0;
            end else if (m_hold) begin
                if (out_ready) begin
                    for (int k = 0; k < 4; k++) m_sum[k] = 0;
                    m_beats = 0; m_hold = 0; m_ovf = '0;
                end
            end else if (in_valid && m_alive) begin
                for (int k = 0; k < 4; k++) m_sum[k] += lane[k];
                m_beats++;
                if (m_beats == STEPS) begin
                    m_hold = 1;
                    for (int k = 0; k < 4; k++) begin
                        m_out[k] = sat(m_sum[k]);
                        m_ovf[k] = (m_out[k] != m_sum[k]);
                    end
                end
            end
            m_alive = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("in_ready", in_ready, (m_alive && !m_hold));
        chk("out_valid", out_valid, m_hold);
        chk("beat_cnt", beat_cnt, m_beats);
        if (m_hold) begin
            chk("out0", out0, m_out[0] & 16'hFFFF);
            chk("out1", out1, m_out[1] & 16'hFFFF);
            chk("out2", out2, m_out[2] & 16'hFFFF);
            chk("out3", out3, m_out[3] & 16'hFFFF);
            chk("ovf", ovf, m_ovf);
        end
    end

    // Drive one cycle of inputs (called just after a falling edge).
    task automatic drive(input bit v, input logic [W-1:0] a, b, c, d,
                         input bit ordy, input bit clr);
        in_valid = v; in0 = a; in1 = b; in2 = c; in3 = d;
        out_ready = ordy; clear = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, '0, '0, 0, 0);
    endtask

    task automatic nominal_result();
        drive(1, 16'h0800, 16'h0600, 16'h0900, 16'h0400, 0, 0);
        drive(1, 16'h0A00, 16'h0000, 16'h0100, 16'h0500, 0, 0);
        drive(1, 16'h0C00, 16'h0300, 16'h0800, 16'h0600, 0, 0);
        drive(1, 16'h0A00, 16'h0100, 16'h0300, 16'h0500, 0, 0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out0", out0, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);

        // Nominal
        nominal_result();
        chk("nom_valid", out_valid, 1);
        chk("nom_out0", out0, 16'h2800);
        chk("nom_out1", out1, 16'h0A00);
        chk("nom_out2", out2, 16'h1500);
        chk("nom_out3", out3, 16'h1400);
        chk("nom_ovf", ovf, 4'b0000);
        drive(0, '0, '0, '0, '0, 1, 0);
        chk("nom_released", out_valid, 0);

        // Saturation; intermediate overflow on lane2 must not clip
        drive(1, 16'h4000, 16'hC000, 16'h7000, 16'h0000, 0, 0);
        drive(1, 16'h4000, 16'hC000, 16'h7000, 16'h0000, 0, 0);
        drive(1, 16'h4000, 16'hC000, 16'h9000, 16'h0000, 0, 0);
        drive(1, 16'h4000, 16'hC000, 16'h9000, 16'h0000, 0, 0);
        chk("sat_out0", out0, 16'h7FFF);
        chk("sat_out1", out1, 16'h8000);
        chk("sat_out2", out2, 16'h0000);
        chk("sat_ovf", ovf, 4'b0011);

        // Backpressure: beats offered in HOLD are ignored
        for (int i = 0; i < 5; i++)
            drive(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0);
        chk("bp_held_out0", out0, 16'h7FFF);
        chk("bp_in_ready", in_ready, 0);
        drive(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0);
        for (int i = 0; i < 4; i++)
            drive(1, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 0, 0);
        chk("bp_next_out0", out0, 16'h0040);
        chk("bp_next_out3", out3, 16'h0100);
        drive(0, '0, '0, '0, '0, 1, 0);

        // Gapped input 1,0,0,1,1,0,1
        begin
            bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
            for (int i = 0; i < 7; i++)
                drive(pat[i], 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        end
        chk("gap_out0", out0, 16'h0400);
        chk("gap_beat_cnt", beat_cnt, 4);
        drive(0, '0, '0, '0, '0, 1, 0);

        // Clear after two beats
        drive(1, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 0, 0);
        drive(1, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 0, 0);
        drive(1, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 0, 1);
        chk("clr_beat_cnt", beat_cnt, 0);
        for (int i = 0; i < 4; i++)
            drive(1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 0);
        chk("clr_out0", out0, 16'h0400);
        // clear together with handshake: result dropped, fresh start
        drive(0, '0, '0, '0, '0, 1, 1);
        chk("clr_hs_valid", out_valid, 0);
        chk("clr_hs_cnt", beat_cnt, 0);
        for (int i = 0; i < 4; i++)
            drive(1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        chk("clr_hs_out0", out0, 16'h0400);

        // Async reset pulse mid-HOLD between edges
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_out0", out0, 0);
        chk("arst_in_ready", in_ready, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_in_ready_back", in_ready, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] d [4];
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0:       d[k] = 16'h7F00 + W'($urandom_range(0, 255));
                    1:       d[k] = 16'h8000 + W'($urandom_range(0, 255));
                    default: d[k] = W'($urandom);
                endcase
            end
            drive(($urandom % 4) != 0, d[0], d[1], d[2], d[3],
                  ($urandom % 3) != 0, ($urandom % 30) == 0);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
